i2c_rx_ctrl: RTL and testbench
==============================

// Module: i2c_rx_ctrl
// PURPOSE
//  Sequences the I2C slave receive datapath for writes only; reads are not handled.
//  Frames each byte from START/STOP and SCL-edge strobes, and gates the rx shift register.
//  Checks the address byte, drives ACK/NACK on SDA, and pushes data bytes into the rx FIFO.
//  Sits between the SDA/SCL edge detectors and the rx shift register / rx FIFO.
// PARAMETERS
//  SLAVE_ADDR  7'h3C  7-bit address this slave answers to
//  NUM_BITS    8      bits per byte (bit counter terminal count)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous, active-high reset
//  start_found   in   1  1-cycle strobe: START or repeated START detected
//  stop_found    in   1  1-cycle strobe: STOP detected
//  rising_edge   in   1  1-cycle strobe: SCL rising edge
//  falling_edge  in   1  1-cycle strobe: SCL falling edge
//  rx_data       in   8  parallel output of the rx shift register, MSB first
//  fifo_full     in   1  rx FIFO cannot accept a byte
//  rx_enable     out  1  enables shifting of the rx shift register (AND'd with rising_edge)
//  sda_ack       out  1  1 = pull SDA low (ACK); 0 = release SDA
//  fifo_load     out  1  1-cycle write strobe to the rx FIFO (data = rx_data)
//  addr_hit      out  1  high from a matched write address until STOP or START
//  nack_err      out  1  1-cycle pulse: data byte NACKed because the FIFO was full
// BEHAVIOUR
//  Reset (async): state=IDLE, bit_cnt=0; every output is 0.
//  States: IDLE, ADDR, ADDR_CHK, ACK, DATA, DATA_CHK, IGNORE.
//  IDLE: start_found -> ADDR, bit_cnt=0.
//  ADDR/DATA: rx_enable=1; bit_cnt++ on each rising_edge.
//   - On the rising_edge that makes bit_cnt==NUM_BITS, go to ADDR_CHK or DATA_CHK
//     on the next cycle, and clear bit_cnt.
//   - rx_data is stable in the *_CHK cycle.
//  ADDR_CHK (1 cycle):
//   - rx_data[7:1]==SLAVE_ADDR && rx_data[0]==0: set addr_hit, ack_pend=1 -> ACK.
//   - Any other byte: -> IGNORE. Mismatched address or read request: no ACK.
//  DATA_CHK (1 cycle):
//   - fifo_full=0: fifo_load=1 this cycle, ack_pend=1 -> ACK.
//   - fifo_full=1: nack_err=1, ack_pend=0 -> ACK. The byte is dropped.
//  ACK:
//   - sda_ack is asserted on the first falling_edge after entry when ack_pend=1.
//   - sda_ack is cleared on the following falling_edge, then -> DATA.
//   - With ack_pend=0, SDA stays released for the ACK slot; same transitions.
//   - rx_enable=0 throughout ACK.
//  IGNORE: all outputs 0; leave only on start_found or stop_found.
//  Priority, every state: start_found > stop_found > edge strobes.
//   - start_found: -> ADDR, bit_cnt=0, sda_ack=0, addr_hit=0. This is the repeated START case.
//   - stop_found: -> IDLE, bit_cnt=0, sda_ack=0, addr_hit=0.
//   - Any partial byte is discarded; no fifo_load for a partial byte.
//  Edge strobes coincident with start_found or stop_found are ignored.
//  rising_edge and falling_edge are never simultaneous; the upstream edge detector guarantees this.
//  Outputs are registered. fifo_load and nack_err are exactly 1 clk wide.
//  Latency: the 8th rising_edge is at cycle t, so fifo_load is at t+1.
//  rst mid-transfer: immediate IDLE. The current byte and ACK are abandoned; SDA is released.
//  bit_cnt width: $clog2(NUM_BITS+1). It never exceeds NUM_BITS.
// TESTING
//  1. START, byte 0x78 (0x3C<<1|W), ACK slot
//     -> addr_hit=1; sda_ack=1 between the next two falling edges.
//  2. Matched address, then byte 0xA5, fifo_full=0
//     -> exactly one fifo_load, rx_data=0xA5 one cycle after the 8th rising edge; ACK driven.
//  3. Address 0x7A (wrong address) or 0x79 (read)
//     -> sda_ack stays 0; later data bytes produce no fifo_load until STOP.
//  4. Data byte with fifo_full=1
//     -> nack_err 1-cycle pulse, no fifo_load, SDA released in the ACK slot;
//        the next byte is accepted once fifo_full=0.
//  5. Repeated START after 4 data bits
//     -> bit_cnt=0, no fifo_load; a new address byte 0x78 is ACKed.
//  6. STOP during the ACK slot, and rst mid-byte
//     -> sda_ack drops within 1 cycle; IDLE; all outputs 0.

Source files
------------

// File: rtl/i2c_rx_ctrl.sv
// rtl/i2c_rx_ctrl.sv - I2C slave write-only receive sequencer
// Frames bytes from SCL strobes, checks the address, drives ACK and loads the rx FIFO.
module i2c_rx_ctrl #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C,
    parameter int         NUM_BITS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       rising_edge,
    input  logic       falling_edge,
    input  logic [7:0] rx_data,
    input  logic       fifo_full,
    output logic       rx_enable,
    output logic       sda_ack,
    output logic       fifo_load,
    output logic       addr_hit,
    output logic       nack_err
);
    localparam int CW = $clog2(NUM_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_CHK, S_ACK, S_DATA, S_DATA_CHK, S_IGNORE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic            r_ack_pend, w_ack_pend_nxt;
    logic            r_ack_phase, w_ack_phase_nxt;
    logic            r_rx_enable, w_rx_enable_nxt;
    logic            r_sda_ack, w_sda_ack_nxt;
    logic            r_addr_hit, w_addr_hit_nxt;
    logic            r_fifo_load, w_fifo_load_nxt;
    logic            r_nack_err, w_nack_err_nxt;
    logic            w_last_bit;

    assign w_last_bit = (r_bit_cnt == CW'(NUM_BITS - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_ack_pend_nxt  = r_ack_pend;
        w_ack_phase_nxt = r_ack_phase;
        w_sda_ack_nxt   = r_sda_ack;
        w_addr_hit_nxt  = r_addr_hit;
        w_fifo_load_nxt = 1'b0;
        w_nack_err_nxt  = 1'b0;
        if (start_found || stop_found) begin
            w_state_nxt    = start_found ? S_ADDR : S_IDLE;
            w_bit_cnt_nxt  = '0;
            w_sda_ack_nxt  = 1'b0;
            w_addr_hit_nxt = 1'b0;
            w_ack_pend_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_DATA: begin
                    if (rising_edge) begin
                        if (w_last_bit) begin
                            w_bit_cnt_nxt = '0;
                            if (r_state == S_ADDR) begin
                                w_state_nxt = S_ADDR_CHK;
                            end else begin
                                // FIFO decision is taken on the last bit so the load lands one cycle later
                                w_state_nxt     = S_DATA_CHK;
                                w_fifo_load_nxt = !fifo_full;
                                w_nack_err_nxt  = fifo_full;
                                w_ack_pend_nxt  = !fifo_full;
                            end
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                end
                S_ADDR_CHK: begin
                    w_ack_phase_nxt = 1'b0;
                    if (rx_data[7:1] == SLAVE_ADDR && !rx_data[0]) begin
                        w_addr_hit_nxt = 1'b1;
                        w_ack_pend_nxt = 1'b1;
                        w_state_nxt    = S_ACK;
                    end else begin
                        w_state_nxt = S_IGNORE;
                    end
                end
                S_DATA_CHK: begin
                    w_ack_phase_nxt = 1'b0;
                    w_state_nxt     = S_ACK;
                end
                S_ACK: begin
                    if (falling_edge) begin
                        if (!r_ack_phase) begin
                            w_sda_ack_nxt   = r_ack_pend;
                            w_ack_phase_nxt = 1'b1;
                        end else begin
                            w_sda_ack_nxt = 1'b0;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = S_DATA;
                        end
                    end
                end
                S_IDLE, S_IGNORE: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
        w_rx_enable_nxt = (w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_ack_pend  <= 1'b0;
            r_ack_phase <= 1'b0;
            r_rx_enable <= 1'b0;
            r_sda_ack   <= 1'b0;
            r_addr_hit  <= 1'b0;
            r_fifo_load <= 1'b0;
            r_nack_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_ack_pend  <= w_ack_pend_nxt;
            r_ack_phase <= w_ack_phase_nxt;
            r_rx_enable <= w_rx_enable_nxt;
            r_sda_ack   <= w_sda_ack_nxt;
            r_addr_hit  <= w_addr_hit_nxt;
            r_fifo_load <= w_fifo_load_nxt;
            r_nack_err  <= w_nack_err_nxt;
        end
    end

    assign rx_enable = r_rx_enable;
    assign sda_ack   = r_sda_ack;
    assign fifo_load = r_fifo_load;
    assign addr_hit  = r_addr_hit;
    assign nack_err  = r_nack_err;
endmodule

// File: tb/tb_i2c_rx_ctrl.sv
// tb/tb_i2c_rx_ctrl.sv - bench for i2c_rx_ctrl against a transaction-level write model
module tb_i2c_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_found = 1'b0;
    logic       stop_found = 1'b0;
    logic       rising_edge = 1'b0;
    logic       falling_edge = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       fifo_full = 1'b0;
    logic       sda_bit = 1'b0;
    logic       rx_enable, sda_ack, fifo_load, addr_hit, nack_err;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, last_re = 0, n_load = 0, n_nack = 0, lat_bad = 0;
    logic [7:0] q_load[$];

    // bus-level model: only the transaction state, no knowledge of RTL states
    bit m_active = 0, m_addr_ok = 0;
    int m_idx = 0;

    i2c_rx_ctrl #(.SLAVE_ADDR(7'h3C), .NUM_BITS(8)) dut (
        .clk(clk), .rst(rst), .start_found(start_found), .stop_found(stop_found),
        .rising_edge(rising_edge), .falling_edge(falling_edge), .rx_data(rx_data),
        .fifo_full(fifo_full), .rx_enable(rx_enable), .sda_ack(sda_ack),
        .fifo_load(fifo_load), .addr_hit(addr_hit), .nack_err(nack_err)
    );

    always #5 clk = ~clk;

    // rx shift register stand-in
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rising_edge) last_re <= cyc;
        if (rx_enable && rising_edge) rx_data <= {rx_data[6:0], sda_bit};
    end

    always @(negedge clk) begin
        if (fifo_load) begin
            n_load++;
            q_load.push_back(rx_data);
            if (cyc - last_re != 1) lat_bad++;
        end
        if (nack_err) n_nack++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int which);
        @(negedge clk);
        case (which)
            0: start_found = 1'b1;
            1: stop_found = 1'b1;
            2: rising_edge = 1'b1;
            default: falling_edge = 1'b1;
        endcase
        @(negedge clk);
        start_found = 1'b0; stop_found = 1'b0; rising_edge = 1'b0; falling_edge = 1'b0;
    endtask

    task automatic do_start();
        strobe(0); idle(2);
        m_active = 1; m_idx = 0; m_addr_ok = 0;
    endtask

    task automatic do_stop();
        strobe(1); idle(2);
        m_active = 0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_bit = b[7-i];
            idle(2); strobe(2); idle(2); strobe(3); idle(1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_enable"}, rx_enable, 0);
        check({tag, "_sda_ack"}, sda_ack, 0);
        check({tag, "_fifo_load"}, fifo_load, 0);
        check({tag, "_addr_hit"}, addr_hit, 0);
        check({tag, "_nack_err"}, nack_err, 0);
    endtask

    // full byte plus ACK slot, expectations from the transaction model
    task automatic byte_xfer(input logic [7:0] b, input bit full);
        bit exp_en, exp_ack, exp_load, exp_nack;
        int l0, k0;
        logic [7:0] got;
        exp_en   = m_active && (m_idx == 0 || m_addr_ok);
        exp_load = 0; exp_nack = 0; exp_ack = 0;
        if (m_active && m_idx == 0) begin
            m_addr_ok = (b[7:1] == 7'h3C) && !b[0];
            exp_ack   = m_addr_ok;
        end else if (m_active && m_addr_ok) begin
            exp_ack = !full; exp_load = !full; exp_nack = full;
        end
        fifo_full = full;
        l0 = n_load; k0 = n_nack;
        idle(1);
        check("rx_enable", rx_enable, exp_en);
        send_bits(b, 8);
        idle(1);
        check("ack_drive", sda_ack, exp_ack);
        strobe(2); idle(1);
        check("ack_hold", sda_ack, exp_ack);
        strobe(3); idle(2);
        check("ack_release", sda_ack, 0);
        check("load_cnt", n_load - l0, exp_load);
        check("nack_cnt", n_nack - k0, exp_nack);
        if (exp_load && q_load.size() > 0) begin
            got = q_load.pop_front();
            check("load_data", got, b);
        end
        if (m_active && m_idx == 0) check("addr_hit", addr_hit, m_addr_ok);
        if (m_active) m_idx++;
        fifo_full = 1'b0;
    endtask

    initial begin
        idle(3);
        check_idle_outputs("reset");
        @(negedge clk) rst = 1'b0;
        idle(2);
        check_idle_outputs("post_reset");

        do_start(); byte_xfer(8'h78, 0); byte_xfer(8'hA5, 0); do_stop();
        check("hit_after_stop", addr_hit, 0);

        do_start(); byte_xfer(8'h7A, 0); byte_xfer(8'h11, 0); do_stop();
        do_start(); byte_xfer(8'h79, 0); byte_xfer(8'h22, 0); do_stop();

        do_start(); byte_xfer(8'h78, 0); byte_xfer(8'h33, 1); byte_xfer(8'h44, 0); do_stop();

        do_start(); byte_xfer(8'h78, 0);
        begin
            int l0;
            l0 = n_load;
            send_bits(8'h55, 4);
            do_start();
            check("rstart_no_load", n_load - l0, 0);
            check("rstart_hit_clr", addr_hit, 0);
        end
        byte_xfer(8'h78, 0); byte_xfer(8'h66, 0); do_stop();

        do_start(); send_bits(8'h78, 8); idle(1);
        check("stop_ack_before", sda_ack, 1);
        strobe(1);
        m_active = 0;
        check_idle_outputs("stop_in_ack");
        idle(2);

        do_start(); send_bits(8'h78, 4);
        @(negedge clk) rst = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk) rst = 1'b0;
        m_active = 0;
        byte_xfer(8'h5A, 0);

        for (int t = 0; t < 20; t++) begin
            logic [7:0] a;
            int nb;
            a  = ($urandom_range(0, 1) == 0) ? 8'h78 : 8'($urandom);
            nb = $urandom_range(1, 3);
            do_start();
            byte_xfer(a, 0);
            for (int j = 0; j < nb; j++) byte_xfer(8'($urandom), $urandom_range(0, 3) == 0);
            do_stop();
        end

        check("load_latency", lat_bad, 0);
        check("queue_drained", q_load.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
